dec_stream: RTL and testbench

- Streaming, parametrised successor of the extended-Hamming (SECDED) decoder.
- Supports any power-of-two codeword length from 8 to MAX_CODEWORD_WIDTH, selected per word by work_mod.
- Two-stage pipeline with valid/ready flow control on both sides, plus saturating statistics counters for corrected and uncorrectable words.
- Sits between the channel/deinterleaver and the info sink in the decode path.

---
 rtl/dec_stream_if.sv | 27 ++
 rtl/dec_stream.sv | 158 +++++++++++++++
 tb/tb_dec_stream.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_stream_if.sv
// Stream bundle for the SECDED decoder: codeword in, corrected info word out.
// Latency: none, wires only.
// Backpressure: valid/ready on both directions; slave side is the decoder.
interface dec_stream_if #(
    parameter int MAX_CODEWORD_WIDTH = 32
);
    localparam int MAX_INFO_WIDTH = MAX_CODEWORD_WIDTH - ($clog2(MAX_CODEWORD_WIDTH) + 1);

    logic                          in_valid;
    logic                          in_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] data_in;
    logic [1:0]                    work_mod;
    logic                          out_valid;
    logic                          out_ready;
    logic [MAX_INFO_WIDTH-1:0]     data_out;
    logic [1:0]                    num_of_errors;

    modport master (
        output in_valid, data_in, work_mod, out_ready,
        input  in_ready, out_valid, data_out, num_of_errors
    );

    modport slave (
        input  in_valid, data_in, work_mod, out_ready,
        output in_ready, out_valid, data_out, num_of_errors
    );
endinterface

// File: rtl/dec_stream.sv
// Streaming extended-Hamming (SECDED) decoder, codeword length 8..MAX per word.
// Latency: 2 cycles accept-to-output, 1 word/cycle throughput.
// Backpressure: each stage advances when empty or draining; in_ready drops only with both stages full and out_ready low.
module dec_stream #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dec_stream_if.slave          bus,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] uncorr_cnt
);
    localparam int MAX_PARITY_WIDTH = $clog2(MAX_CODEWORD_WIDTH) + 1;
    localparam int MAX_INFO_WIDTH   = MAX_CODEWORD_WIDTH - MAX_PARITY_WIDTH;
    localparam int RW               = MAX_PARITY_WIDTH - 1;   // widest syndrome
    localparam logic [1:0] MAX_MODE = 2'($clog2(MAX_CODEWORD_WIDTH) - 3);

    // Column of info bit idx: idx-th non-power-of-two integer counting up from 3.
    // Columns do not depend on the mode, so one table serves every codeword length.
    function automatic int col_of(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int v = 3; v < 2 * MAX_CODEWORD_WIDTH; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (cnt == idx) res = v;
                cnt++;
            end
        end
        return res;
    endfunction

    logic [RW-1:0] h_tab [MAX_INFO_WIDTH];

    for (genvar gi = 0; gi < MAX_INFO_WIDTH; gi++) begin : g_col
        assign h_tab[gi] = RW'(col_of(gi));
    end

    // Stage 1 inputs
    logic [6:0]                    in_n;
    logic [2:0]                    in_r;
    logic [MAX_CODEWORD_WIDTH-1:0] in_cw;
    logic [MAX_INFO_WIDTH-1:0]     in_info;
    logic [RW-1:0]                 in_syn;
    logic                          in_po;

    // Stage 1 registers
    logic                          s1_valid;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_cw;
    logic [1:0]                    s1_mode;
    logic [RW-1:0]                 s1_syn;
    logic                          s1_po;

    // Stage 2 inputs / registers
    logic [MAX_INFO_WIDTH-1:0]     s1_info;
    logic [MAX_INFO_WIDTH-1:0]     s1_flip;
    logic [MAX_INFO_WIDTH-1:0]     s2_dat_nxt;
    logic [1:0]                    s2_err_nxt;
    logic                          s2_valid;
    logic [MAX_INFO_WIDTH-1:0]     s2_dat;
    logic [1:0]                    s2_err;

    logic s1_advance;
    logic s2_advance;
    logic out_hs;

    assign s2_advance   = !s2_valid || bus.out_ready;
    assign s1_advance   = s2_advance;
    assign bus.in_ready = !s1_valid || s1_advance;
    assign out_hs       = s2_valid && bus.out_ready;

    assign bus.out_valid     = s2_valid;
    assign bus.data_out      = s2_dat;
    assign bus.num_of_errors = s2_err;

    // Mask the codeword to N bits, then form syndrome and overall parity.
    // Info bits above K are zero after masking, so they never touch the syndrome.
    always_comb begin
        in_n    = 7'd8 << bus.work_mod;
        in_r    = 3'd3 + {1'b0, bus.work_mod};
        in_cw   = bus.data_in & ~({MAX_CODEWORD_WIDTH{1'b1}} << in_n);
        in_info = MAX_INFO_WIDTH'(in_cw >> (in_r + 3'd1));
        in_syn  = in_cw[RW-1:0] & ((RW'(1) << in_r) - RW'(1));
        for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
            if (in_info[i]) in_syn = in_syn ^ h_tab[i];
        end
        in_po   = ^in_cw;
    end

    // Stage 1 register: loads whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_mode  <= '0;
            s1_syn   <= '0;
            s1_po    <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cw   <= in_cw;
                s1_mode <= bus.work_mod;
                s1_syn  <= in_syn;
                s1_po   <= in_po;
            end
        end
    end

    // Classify and correct: a single error whose syndrome matches an info column flips that bit;
    // check-bit and overall-parity errors leave the info untouched.
    always_comb begin
        s1_info = MAX_INFO_WIDTH'(s1_cw >> (3'd4 + {1'b0, s1_mode}));
        s1_flip = '0;
        for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
            s1_flip[i] = s1_po && (h_tab[i] == s1_syn);
        end
        s2_dat_nxt = s1_info;
        s2_err_nxt = 2'd0;
        if (s1_mode > MAX_MODE) begin
            s2_dat_nxt = '0;
            s2_err_nxt = 2'd3;
        end else if (s1_po) begin
            s2_dat_nxt = s1_info ^ s1_flip;
            s2_err_nxt = 2'd1;
        end else if (s1_syn != '0) begin
            s2_err_nxt = 2'd2;
        end
    end

    // Stage 2 register: output holds while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_dat   <= '0;
            s2_err   <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_dat <= s2_dat_nxt;
                s2_err <= s2_err_nxt;
            end
        end
    end

    // Saturating statistics on output handshakes; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (s2_err == 2'd1 && corr_cnt != '1)   corr_cnt   <= corr_cnt + 1'b1;
            if (s2_err == 2'd2 && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dec_stream.sv
// Self-checking bench for dec_stream with a brute-force SECDED reference model.
// Latency: checks 2-cycle accept-to-output and 1 word/cycle streaming.
// Backpressure: random out_ready stream, stall-hold and in_ready checks every cycle.
module tb_dec_stream;
    localparam int MAXN = 32;
    localparam int MAXK = 26;
    localparam int CW   = 2;
    localparam int SAT  = (1 << CW) - 1;

    typedef struct packed {
        logic [MAXK-1:0] dat;
        logic [1:0]      err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    dec_stream_if #(.MAX_CODEWORD_WIDTH(MAXN)) bus();

    dec_stream #(.MAX_CODEWORD_WIDTH(MAXN), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clear  (cnt_clear),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    exp_t            q[$];
    int              mdl_corr = 0;
    int              mdl_uncorr = 0;
    bit              prev_stall = 1'b0;
    logic [MAXK-1:0] prev_dat;
    logic [1:0]      prev_err;
    logic [MAXK-1:0] last_dat = '0;
    logic [1:0]      last_err = '0;
    int              n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, req);
        end
    endtask

    // ---------------- reference model (codeword-level, brute force) ----------------
    function automatic int hcol(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int v = 3; v < 64; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (cnt == idx) res = v;
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] enc(input logic [MAXK-1:0] info, input logic [1:0] m);
        int n, r, p, k;
        logic [31:0] cw;
        n = 8 << m;
        r = 3 + int'(m);
        p = r + 1;
        k = n - p;
        cw = '0;
        for (int i = 0; i < k; i++) begin
            if (info[i]) begin
                cw = cw | (32'd1 << (p + i));
                for (int j = 0; j < r; j++)
                    if (((hcol(i) >> j) & 1) == 1) cw = cw ^ (32'd1 << j);
            end
        end
        if (^cw) cw = cw | (32'd1 << (p - 1));
        return cw;
    endfunction

    function automatic logic [MAXK-1:0] ext(input logic [31:0] cw, input logic [1:0] m);
        int p, k;
        p = 4 + int'(m);
        k = (8 << m) - p;
        return MAXK'((cw >> p) & ((32'd1 << k) - 32'd1));
    endfunction

    function automatic bit is_cw(input logic [31:0] cw, input logic [1:0] m);
        return enc(ext(cw, m), m) == cw;
    endfunction

    // Decode by search: valid codeword -> clean; one flip away -> corrected; else uncorrectable.
    function automatic exp_t model(input logic [31:0] din, input logic [1:0] m);
        exp_t e;
        int n;
        logic [31:0] cw;
        logic [31:0] t;
        n = 8 << m;
        if (n > MAXN) begin
            e.dat = '0;
            e.err = 2'd3;
            return e;
        end
        cw = (n >= 32) ? din : (din & ((32'd1 << n) - 32'd1));
        e.dat = ext(cw, m);
        e.err = 2'd0;
        if (!is_cw(cw, m)) begin
            e.err = 2'd2;
            for (int b = 0; b < n; b++) begin
                t = cw ^ (32'd1 << b);
                if (is_cw(t, m)) begin
                    e.err = 2'd1;
                    e.dat = ext(t, m);
                end
            end
        end
        return e;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    task automatic mon();
        exp_t e;
        if (rst) begin
            q.delete();
            mdl_corr   = 0;
            mdl_uncorr = 0;
            prev_stall = 1'b0;
            return;
        end
        chk("corr_cnt", 32'(corr_cnt), 32'(mdl_corr));
        chk("uncorr_cnt", 32'(uncorr_cnt), 32'(mdl_uncorr));
        chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
        if (q.size() == 0) chk("out_valid_empty", 32'(bus.out_valid), 32'd0);
        if (q.size() == 2) chk("out_valid_full", 32'(bus.out_valid), 32'd1);
        if (prev_stall) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.data_out), 32'(prev_dat));
            chk("hold_err", 32'(bus.num_of_errors), 32'(prev_err));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output at %0t: got data 0x%0h, required no word", $time, bus.data_out);
            end else begin
                e = q.pop_front();
                chk("data_out", 32'(bus.data_out), 32'(e.dat));
                chk("num_of_errors", 32'(bus.num_of_errors), 32'(e.err));
                last_dat = bus.data_out;
                last_err = bus.num_of_errors;
                n_out++;
                if (e.err == 2'd1 && mdl_corr < SAT) mdl_corr++;
                if (e.err == 2'd2 && mdl_uncorr < SAT) mdl_uncorr++;
            end
        end
        if (cnt_clear) begin
            mdl_corr   = 0;
            mdl_uncorr = 0;
        end
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.data_in, bus.work_mod));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_dat   = bus.data_out;
        prev_err   = bus.num_of_errors;
    endtask

    // ---------------- drivers (always entered at posedge + 1) ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] d);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        bus.work_mod = m;
        @(negedge clk);
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        align();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        align();
    endtask

    task automatic wait_ov();
        int g;
        g = 0;
        while (!bus.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    // Hand-computed vectors: mode, codeword, info, num_of_errors.
    logic [1:0]  tm [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [31:0] td [10] = '{32'hB1, 32'h91, 32'h31, 32'h90, 32'h12345678,
                             32'h33, 32'h433, 32'h30, 32'h43, 32'hFFFFFFB1};
    logic [MAXK-1:0] tx [10] = '{26'hB, 26'hB, 26'hB, 26'h9, 26'h0, 26'h1, 26'h1, 26'h1, 26'h1, 26'hB};
    logic [1:0]  te [10] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};

    initial begin
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.work_mod  = '0;
        bus.out_ready = 1'b1;
        fork
            forever begin
                @(negedge clk);
                mon();
            end
            begin : main_seq
                exp_t e;
                logic [31:0] cw;
                logic [MAXK-1:0] info;
                logic [1:0] wm [20];
                logic [31:0] wd [20];
                int n, sent, g, n0;
                bit acc;

                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_data_out", 32'(bus.data_out), 32'd0);
                chk("rst_num_err", 32'(bus.num_of_errors), 32'd0);
                chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
                chk("rst_corr", 32'(corr_cnt), 32'd0);
                align();

                // Latency: accepted on one edge, visible after the second.
                send(2'd0, 32'hB1);
                @(negedge clk);
                chk("lat_1cyc_valid", 32'(bus.out_valid), 32'd0);
                @(negedge clk);
                chk("lat_2cyc_valid", 32'(bus.out_valid), 32'd1);
                chk("lat_2cyc_data", 32'(bus.data_out), 32'hB);
                drain();

                // Directed literals: pin the model, then the DUT.
                for (int i = 0; i < 10; i++) begin
                    e = model(td[i], tm[i]);
                    chk("model_dat", 32'(e.dat), 32'(tx[i]));
                    chk("model_err", 32'(e.err), 32'(te[i]));
                    send(tm[i], td[i]);
                    drain();
                    chk("dut_dat", 32'(last_dat), 32'(tx[i]));
                    chk("dut_err", 32'(last_err), 32'(te[i]));
                end

                // Every single and double flip of a random codeword, modes 1 and 2.
                for (int m = 1; m <= 2; m++) begin
                    n    = 8 << m;
                    info = MAXK'($urandom) & MAXK'((32'd1 << (n - m - 4)) - 32'd1);
                    cw   = enc(info, 2'(m));
                    for (int b = 0; b < n; b++) begin
                        e = model(cw ^ (32'd1 << b), 2'(m));
                        chk("sweep1_err", 32'(e.err), 32'd1);
                        chk("sweep1_dat", 32'(e.dat), 32'(info));
                        send(2'(m), cw ^ (32'd1 << b));
                    end
                    for (int b = 0; b < n; b++) begin
                        for (int c = b + 1; c < n; c++) begin
                            e = model(cw ^ (32'd1 << b) ^ (32'd1 << c), 2'(m));
                            chk("sweep2_err", 32'(e.err), 32'd2);
                            send(2'(m), cw ^ (32'd1 << b) ^ (32'd1 << c));
                        end
                    end
                    drain();
                end

                // Random stream with random gaps and random out_ready.
                for (int i = 0; i < 20; i++) begin
                    wm[i] = 2'($urandom_range(0, 3));
                    n     = (wm[i] == 2'd3) ? 8 : (8 << wm[i]);
                    info  = MAXK'($urandom);
                    wd[i] = enc(info, (wm[i] == 2'd3) ? 2'd0 : wm[i]);
                    if ($urandom_range(0, 2) != 0) wd[i] = wd[i] ^ (32'd1 << $urandom_range(0, n - 1));
                    if ($urandom_range(0, 3) == 0) wd[i] = wd[i] ^ (32'd1 << $urandom_range(0, n - 1));
                end
                n0 = n_out;
                sent = 0;
                g = 0;
                while (sent < 20 && g < 2000) begin
                    @(negedge clk);
                    acc = bus.in_valid && bus.in_ready;
                    align();
                    g++;
                    if (acc) sent++;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    if (acc || !bus.in_valid) begin
                        if (sent < 20 && $urandom_range(0, 3) != 0) begin
                            bus.in_valid = 1'b1;
                            bus.data_in  = wd[sent];
                            bus.work_mod = wm[sent];
                        end else begin
                            bus.in_valid = 1'b0;
                        end
                    end
                end
                chk("stream_sent", 32'(sent), 32'd20);
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
                drain();
                chk("stream_count", 32'(n_out - n0), 32'd20);

                // Saturation at all-ones with a 2-bit counter.
                cnt_clear = 1'b1;
                align();
                cnt_clear = 1'b0;
                for (int i = 0; i < 5; i++) send(2'd0, 32'h91);
                drain();
                @(negedge clk);
                chk("corr_saturated", 32'(corr_cnt), 32'd3);
                align();

                // Clear coinciding with a correctable handshake: clear wins.
                bus.out_ready = 1'b0;
                send(2'd0, 32'h91);
                wait_ov();
                align();
                n0 = n_out;
                bus.out_ready = 1'b1;
                cnt_clear = 1'b1;
                align();
                cnt_clear = 1'b0;
                @(negedge clk);
                chk("clear_wins", 32'(corr_cnt), 32'd0);
                chk("clear_word_out", 32'(n_out - n0), 32'd1);
                align();

                // Reset with two words in flight.
                bus.out_ready = 1'b0;
                send(2'd0, 32'hB1);
                send(2'd0, 32'h91);
                @(negedge clk);
                chk("full_in_ready", 32'(bus.in_ready), 32'd0);
                align();
                rst = 1'b1;
                align();
                rst = 1'b0;
                @(negedge clk);
                chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("midrst_data_out", 32'(bus.data_out), 32'd0);
                chk("midrst_num_err", 32'(bus.num_of_errors), 32'd0);
                chk("midrst_corr", 32'(corr_cnt), 32'd0);
                chk("midrst_uncorr", 32'(uncorr_cnt), 32'd0);
                chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
                align();
                bus.out_ready = 1'b1;
                send(2'd0, 32'h90);
                drain();
                chk("post_rst_err", 32'(last_err), 32'd2);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
